sram_burst_arbiter: RTL and testbench
=====================================

# sram_burst_arbiter

Two-requester burst controller that shares one single-port SRAM between independent masters. It accepts burst requests (read or write, start address), arbitrates round-robin, and sequences BURST_LEN back-to-back beats with incrementing addresses onto the SRAM port. It returns read data and write-beat acknowledgements to the granted requester. It sits between the requesters and the SRAM in place of a free-running address generator.

## Interface
- ADDR_WIDTH, 16, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- BURST_LEN, 8, beats per burst; legal range 1..256.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [1:0]  burst request per requester; held until accepted.
- req_write  in  [1:0]  1 = write burst, 0 = read burst; qualified by req_valid.
- req_addr  in  [1:0][ADDR_WIDTH-1:0]  burst start address per requester.
- req_ready  out  [1:0]  one-hot acceptance pulse.
- wr_data  in  [1:0][DATA_WIDTH-1:0]  current write beat per requester.
- wr_ack  out  [1:0]  write beat consumed this cycle; requester advances to the next beat on the following cycle.
- rd_data  out  DATA_WIDTH  read beat; direct pass-through of mem_rd_data.
- rd_valid  out  [1:0]  rd_data valid for that requester.
- done  out  [1:0]  one-cycle pulse at burst completion.
- busy  out  1  high whenever state is not IDLE.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wren  out  1  SRAM write enable.
- mem_rden  out  1  SRAM read enable.
- mem_wr_data  out  DATA_WIDTH  SRAM write data.
- mem_rd_data  in  DATA_WIDTH  SRAM read data; valid one cycle after mem_rden.

## Operation
- **States:**
  - IDLE: arbitrate. When any req_valid is set, assert req_ready for the winner, latch its address, direction and id (gnt), clear the beat counter, and go to BURST.
  - BURST: issue one beat per cycle. After beat BURST_LEN-1, go to DRAIN for a read burst, or to IDLE with done[gnt] for a write burst.
  - DRAIN: rd_valid[gnt] for the last read beat, done[gnt], then IDLE.
- **Arbitration:**
  - Round-robin via last_gnt pointer.
  - Single requester: granted.
  - Both requesters: grant the one not equal to last_gnt.
  - last_gnt updates on each acceptance.
  - Reset value of last_gnt is 1, so requester 0 wins the first tie.
- **Beats:**
  - mem_addr = latched_addr + beat_cnt, modulo 2^ADDR_WIDTH; wraps from max to 0 without error.
  - Beat counter width is clog2(BURST_LEN), minimum 1 bit.
- **Write beat:** mem_wren=1, mem_wr_data=wr_data[gnt] (combinational mux), wr_ack[gnt]=1.
- **Read beat:** mem_rden=1. rd_valid[gnt] is a one-cycle registered delay of mem_rden, gated to the granted requester.
- **Enables and acks:** mem_wren and mem_rden are never both high. Both are low outside BURST. wr_ack and rd_valid are only ever set for gnt.
- **Requests during a burst:** req_valid changes while busy are ignored. The next arbitration occurs only in IDLE.
- **Reset:** rst has priority over all activity.
  - Reset values: state IDLE, all outputs 0, counters 0, last_gnt 1.
  - Reset mid-burst abandons the burst. No done is issued, and rd_valid is 0 on the cycle after reset even if a read was outstanding.

## Timing
- Acceptance cycle T: req_ready high in IDLE.
- First beat on mem_* at T+1; last beat at T+BURST_LEN.
- Write burst: done at T+BURST_LEN+1, with state IDLE in the same cycle. The next acceptance is possible that cycle.
- Read burst:
  - rd_valid at T+2 .. T+BURST_LEN+1.
  - The last rd_valid coincides with DRAIN and done.
  - IDLE at T+BURST_LEN+2.
- Turnaround: one idle (arbitration) cycle between consecutive bursts. Occupancy per burst is BURST_LEN+1 cycles for a write and BURST_LEN+2 for a read.
- req_ready, wr_ack, mem_* and busy are decoded from registered state. rd_valid and done are registered.

## Test plan
- Reset, single write by req 0, addr 0x0010, data 0xA0..0xA7 -> mem_wren T+1..T+8, mem_addr 0x0010..0x0017, wr_ack[0] x8, done[0] at T+9.
- Read back the same region with req 1 -> rd_valid[1] T+2..T+9, rd_data 0xA0..0xA7 in order, done[1] at T+9, busy low at T+10.
- req_valid=2'b11 held continuously after reset -> grants alternate 0,1,0,1 and no requester is granted twice in a row.
- Write burst at 0xFFFC -> mem_addr FFFC, FFFD, FFFE, FFFF, 0000..0003; readback matches.
- rst asserted at beat 3 of a read -> next cycle all outputs 0, no done, no further rd_valid; a new request is accepted normally with requester 0 winning the tie.
- BURST_LEN=1 build: write then read -> single beat each, done at T+2 (write) and T+2 (read, rd_valid same cycle).

Source files
------------

// File: rtl/sram_burst_arbiter_if.sv
// Requester-side and SRAM-side signals of the two-master burst arbiter.
// slave = the arbiter; master = the requesters plus the SRAM read return.
interface sram_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_write;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0]                 req_ready;
  logic [1:0][DATA_WIDTH-1:0] wr_data;
  logic [1:0]                 wr_ack;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic [1:0]                 rd_valid;
  logic [1:0]                 done;
  logic                       busy;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic                       mem_wren;
  logic                       mem_rden;
  logic [DATA_WIDTH-1:0]      mem_wr_data;
  logic [DATA_WIDTH-1:0]      mem_rd_data;

  modport slave (
    input  req_valid, req_write, req_addr, wr_data, mem_rd_data,
    output req_ready, wr_ack, rd_data, rd_valid, done, busy,
           mem_addr, mem_wren, mem_rden, mem_wr_data
  );

  modport master (
    output req_valid, req_write, req_addr, wr_data, mem_rd_data,
    input  req_ready, wr_ack, rd_data, rd_valid, done, busy,
           mem_addr, mem_wren, mem_rden, mem_wr_data
  );
endinterface

// File: rtl/sram_burst_arbiter.sv
// Round-robin burst controller sharing one single-port SRAM between two requesters.
// Each granted burst issues BURST_LEN back-to-back beats at incrementing addresses.
module sram_burst_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  sram_burst_arbiter_if.slave bus
);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [BEAT_W-1:0]     beat_reg, beat_next;
  logic                  write_reg;
  logic                  gnt_reg;
  logic                  last_gnt_reg;
  logic [1:0]            rd_valid_reg, rd_valid_next;
  logic [1:0]            done_reg, done_next;

  logic                  win;
  logic                  accept;
  logic                  last_beat;
  logic [1:0]            gnt_sel;
  logic [1:0]            win_sel;

  logic                  busy;
  logic                  mem_wren;
  logic                  mem_rden;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  // A tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    if (&bus.req_valid) begin
      win = ~last_gnt_reg;
    end else begin
      win = ~bus.req_valid[0];
    end
  end

  assign accept    = (state_reg == IDLE) && (|bus.req_valid) && !rst;
  assign last_beat = (beat_reg == LAST_BEAT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      assign gnt_sel[gi] = (gnt_reg == 1'(gi));
      assign win_sel[gi] = (win == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (last_beat) begin
          state_next = write_reg ? IDLE : DRAIN;
        end
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    mem_wren    = (state_reg == BURST) && write_reg;
    mem_rden    = (state_reg == BURST) && !write_reg;
    mem_addr    = addr_reg + ADDR_WIDTH'(beat_reg);
    mem_wr_data = mem_wren ? bus.wr_data[gnt_reg] : '0;
  end

  always_comb begin
    beat_next = beat_reg;
    if (accept) begin
      beat_next = '0;
    end else if ((state_reg == BURST) && !last_beat) begin
      beat_next = beat_reg + 1'b1;
    end
    // Read data returns one cycle after the enable, so rd_valid trails mem_rden.
    rd_valid_next = mem_rden ? gnt_sel : 2'b00;
    done_next     = ((state_reg == BURST) && last_beat) ? gnt_sel : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      beat_reg     <= '0;
      write_reg    <= 1'b0;
      gnt_reg      <= 1'b0;
      last_gnt_reg <= 1'b1;
      rd_valid_reg <= 2'b00;
      done_reg     <= 2'b00;
    end else begin
      beat_reg     <= beat_next;
      rd_valid_reg <= rd_valid_next;
      done_reg     <= done_next;
      if (accept) begin
        addr_reg     <= bus.req_addr[win];
        write_reg    <= bus.req_write[win];
        gnt_reg      <= win;
        last_gnt_reg <= win;
      end
    end
  end

  assign bus.req_ready   = accept ? win_sel : 2'b00;
  assign bus.wr_ack      = mem_wren ? gnt_sel : 2'b00;
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.done        = done_reg;
  assign bus.rd_data     = bus.mem_rd_data;
  assign bus.busy        = busy;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wren    = mem_wren;
  assign bus.mem_rden    = mem_rden;
  assign bus.mem_wr_data = mem_wr_data;
endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Scoreboard bench: a burst-level model predicts grants, beats, read data and done
// timing at acceptance; an independent monitor compares what the DUT presents.
module tb_sram_burst_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int BL = 8;

  typedef struct packed {
    logic                 wr;
    logic [AW-1:0]        addr;
    logic [BL-1:0][DW-1:0] data;
  } job_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          wr;
    logic          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          id;
    logic [DW-1:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;

  sram_burst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_burst_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // SRAM environment: synchronous write, read data one cycle after mem_rden.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial begin
    for (int a = 0; a < (1 << AW); a++) sram[a] <= DW'(a) ^ DW'(a >> 8) ^ 8'h5A;
  end
  always @(posedge clk) begin
    if (bus.mem_wren) sram[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rden) bus.mem_rd_data <= sram[bus.mem_addr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  job_t          jobs [2][$];
  job_t          cur [2];
  logic [DW-1:0] wrq [2][$];
  beat_t         beat_q[$];
  ev_t           rdv_q[$];
  ev_t           done_q[$];
  logic [1:0]    reqv;
  logic [1:0]    acc;
  logic [1:0]    ack_s;
  logic          mdl_last;
  logic [31:0]   free_cyc;
  logic [31:0]   last_t;
  logic          rst_req;
  logic          chk_zero;
  int            gap_pct;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic issue(input logic id, input job_t j, input logic [31:0] t);
    beat_t         b;
    ev_t           e;
    logic [AW-1:0] a;
    for (int k = 0; k < BL; k++) begin
      a      = j.addr + AW'(k);
      b.cyc  = t + 32'd1 + 32'(k);
      b.wr   = j.wr;
      b.id   = id;
      b.addr = a;
      b.data = j.wr ? j.data[k] : '0;
      beat_q.push_back(b);
      if (j.wr) begin
        ref_mem[a] = j.data[k];
      end else begin
        e.cyc  = t + 32'd2 + 32'(k);
        e.id   = id;
        e.data = ref_mem[a];
        rdv_q.push_back(e);
      end
    end
    e.cyc  = t + 32'(BL) + 32'd1;
    e.id   = id;
    e.data = '0;
    done_q.push_back(e);
    last_t   = t;
    free_cyc = t + 32'(BL) + (j.wr ? 32'd1 : 32'd2);
  endtask

  // Runs at the negedge of cycle c: decides acceptance from the round-robin rule
  // and the arbiter's occupancy, then checks req_ready and busy.
  task automatic model_step();
    logic [31:0] c;
    logic [1:0]  exp_ready;
    logic        w;
    c         = cyc;
    exp_ready = 2'b00;
    acc       = 2'b00;
    ack_s     = bus.wr_ack;
    if (rst) begin
      while (beat_q.size() > 0 && beat_q[$].cyc >= c) void'(beat_q.pop_back());
      while (rdv_q.size() > 0 && rdv_q[$].cyc >= c) void'(rdv_q.pop_back());
      while (done_q.size() > 0 && done_q[$].cyc >= c) void'(done_q.pop_back());
      wrq[0].delete();
      wrq[1].delete();
      free_cyc = c + 32'd1;
      last_t   = c;
      mdl_last = 1'b1;
      chk_zero = 1'b1;
    end else begin
      if (chk_zero) begin
        check("reset_outputs", {bus.req_ready, bus.wr_ack, bus.rd_valid, bus.done, bus.busy,
                                bus.mem_addr, bus.mem_wren, bus.mem_rden, bus.mem_wr_data}, 64'd0);
        chk_zero = 1'b0;
      end
      if (c >= free_cyc && reqv != 2'b00) begin
        w = (reqv == 2'b11) ? ~mdl_last : (reqv[0] ? 1'b0 : 1'b1);
        exp_ready[w] = 1'b1;
        acc[w]       = 1'b1;
        mdl_last     = w;
        issue(w, cur[w], c);
      end
      check("req_ready", bus.req_ready, exp_ready);
      check("busy", bus.busy, (c > last_t) && (c < free_cyc));
    end
  endtask

  // Runs just after the rising edge: requesters react to grants and write acks.
  task automatic drive_update();
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        reqv[i] = 1'b0;
        if (cur[i].wr) begin
          for (int k = 0; k < BL; k++) wrq[i].push_back(cur[i].data[k]);
        end
      end
      if (ack_s[i] && wrq[i].size() > 0) void'(wrq[i].pop_front());
      if (!reqv[i] && jobs[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        cur[i]  = jobs[i].pop_front();
        reqv[i] = 1'b1;
      end
      bus.wr_data[i]  = (wrq[i].size() > 0) ? wrq[i][0] : '0;
      bus.req_addr[i] = cur[i].addr;
      bus.req_write[i] = cur[i].wr;
    end
    bus.req_valid = reqv;
    rst = rst_req;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive_update();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((jobs[0].size() > 0 || jobs[1].size() > 0 || reqv != 2'b00 || beat_q.size() > 0 ||
            rdv_q.size() > 0 || done_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", (n < budget), 64'd1);
    step();
    step();
  endtask

  function automatic job_t make_job(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] base);
    job_t j;
    j.wr   = wr;
    j.addr = addr;
    for (int k = 0; k < BL; k++) j.data[k] = base + DW'(k);
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.wr   = 1'($urandom_range(1));
    j.addr = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(47));
    for (int k = 0; k < BL; k++) j.data[k] = DW'($urandom);
    return j;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a beat, rd_valid or done.
  task automatic monitor_cycle();
    logic [31:0] c;
    beat_t       b;
    ev_t         e;
    c = cyc;
    if (bus.mem_wren || bus.mem_rden) begin
      check("mem_en_exclusive", bus.mem_wren & bus.mem_rden, 64'd0);
      if (beat_q.size() == 0) begin
        check("unexpected_beat", {bus.mem_wren, bus.mem_rden}, 64'd0);
      end else begin
        b = beat_q.pop_front();
        check("beat_cycle", c, b.cyc);
        check("beat_dir", bus.mem_wren, b.wr);
        check("mem_addr", bus.mem_addr, b.addr);
        if (b.wr) check("mem_wr_data", bus.mem_wr_data, b.data);
        check("wr_ack", bus.wr_ack, b.wr ? (64'd1 << b.id) : 64'd0);
      end
    end else begin
      if (bus.wr_ack != 2'b00) check("wr_ack_stray", bus.wr_ack, 64'd0);
      if (beat_q.size() > 0 && beat_q[0].cyc <= c) begin
        check("beat_present", bus.mem_wren | bus.mem_rden, 64'd1);
        void'(beat_q.pop_front());
      end
    end
    if (bus.rd_valid != 2'b00) begin
      if (rdv_q.size() == 0) begin
        check("rd_valid_stray", bus.rd_valid, 64'd0);
      end else begin
        e = rdv_q.pop_front();
        check("rd_cycle", c, e.cyc);
        check("rd_valid", bus.rd_valid, 64'd1 << e.id);
        check("rd_data", bus.rd_data, e.data);
      end
    end else if (rdv_q.size() > 0 && rdv_q[0].cyc <= c) begin
      check("rd_valid_present", |bus.rd_valid, 64'd1);
      void'(rdv_q.pop_front());
    end
    if (bus.done != 2'b00) begin
      if (done_q.size() == 0) begin
        check("done_stray", bus.done, 64'd0);
      end else begin
        e = done_q.pop_front();
        check("done_cycle", c, e.cyc);
        check("done", bus.done, 64'd1 << e.id);
      end
    end else if (done_q.size() > 0 && done_q[0].cyc <= c) begin
      check("done_present", |bus.done, 64'd1);
      void'(done_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) monitor_cycle();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = DW'(a) ^ DW'(a >> 8) ^ 8'h5A;
    rst           = 1'b1;
    rst_req       = 1'b1;
    reqv          = 2'b00;
    acc           = 2'b00;
    ack_s         = 2'b00;
    mdl_last      = 1'b1;
    free_cyc      = 32'd0;
    last_t        = 32'd0;
    chk_zero      = 1'b0;
    gap_pct       = 0;
    cur[0]        = '0;
    cur[1]        = '0;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.wr_data   = '0;

    repeat (3) step();
    rst_req = 1'b0;
    step();
    step();

    // Directed write by requester 0, then readback by requester 1
    jobs[0].push_back(make_job(1'b1, 16'h0010, 8'hA0));
    run_idle(100);
    $display("txn write id=0 addr=0010 done");
    jobs[1].push_back(make_job(1'b0, 16'h0010, 8'h00));
    run_idle(100);
    $display("txn read id=1 addr=0010 done");

    // Both requesters continuously valid: grants must alternate
    for (int i = 0; i < 4; i++) begin
      jobs[0].push_back(rand_job());
      jobs[1].push_back(rand_job());
    end
    run_idle(400);
    $display("txn tie sequence of 8 bursts done");

    // Address wrap at the top of the SRAM
    jobs[0].push_back(make_job(1'b1, 16'hFFFC, 8'h30));
    run_idle(100);
    jobs[1].push_back(make_job(1'b0, 16'hFFFC, 8'h00));
    run_idle(100);
    $display("txn wrap write/read addr=FFFC done");

    // Reset during beat 3 of a read, then a fresh tie
    begin
      int n;
      n = 0;
      jobs[1].push_back(make_job(1'b0, 16'h0010, 8'h00));
      step();
      while (acc[1] != 1'b1 && n < 20) begin
        step();
        n++;
      end
      check("abort_read_granted", acc[1], 64'd1);
      step();
      step();
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      step();
      step();
      jobs[0].push_back(make_job(1'b1, 16'h0100, 8'h55));
      jobs[1].push_back(make_job(1'b1, 16'h0200, 8'h66));
      run_idle(200);
      $display("txn reset mid-read and post-reset tie done");
    end

    // Randomized mixed traffic with random request gaps
    gap_pct = 40;
    for (int i = 0; i < 12; i++) begin
      jobs[0].push_back(rand_job());
      jobs[1].push_back(rand_job());
    end
    run_idle(2000);
    $display("txn random traffic of 24 bursts done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
